// File: rtl/rv_imm_gen_pipe.sv
// rtl/rv_imm_gen_pipe.sv - registered rv32/rv64 immediate generator with 2-entry skid buffer
// Optional IMM_GEN_PC_TARGET_EN adds pc_in/target_out (pc + imm carried with each word).
module rv_imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              flush_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [31:7]       instr_in,
    input  logic [2:0]        imm_type_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [XLEN-1:0]   imm_out,
    output logic [2:0]        imm_type_out,
`ifdef IMM_GEN_PC_TARGET_EN
    input  logic [XLEN-1:0]   pc_in,
    output logic [XLEN-1:0]   target_out,
`endif
    output logic [TAG_W-1:0]  tag_out
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("rv_imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

`ifdef IMM_GEN_PC_TARGET_EN
    localparam int PW = 2 * XLEN + 3 + TAG_W;
`else
    localparam int PW = XLEN + 3 + TAG_W;
`endif

    logic [XLEN-1:0] dec_imm;
    logic [PW-1:0]   dec_word;
    logic [PW-1:0]   or_data;
    logic [PW-1:0]   sk_data;
    logic            or_valid;
    logic            sk_valid;
    logic            ready_q;

    // Fill with the sign first, then overwrite the low field; keeps U correct for both XLENs.
    always_comb begin
        dec_imm = {XLEN{instr_in[31]}};
        case (imm_type_in)
            3'b010: dec_imm[11:0] = {instr_in[31:25], instr_in[11:7]};
            3'b011: dec_imm[12:0] = {instr_in[31], instr_in[7], instr_in[30:25],
                                     instr_in[11:8], 1'b0};
            3'b100: dec_imm[31:0] = {instr_in[31:12], 12'h000};
            3'b101: dec_imm[20:0] = {instr_in[31], instr_in[19:12], instr_in[20],
                                     instr_in[30:21], 1'b0};
            3'b110: begin
                dec_imm      = '0;
                dec_imm[4:0] = instr_in[19:15];
            end
            3'b111: begin
                dec_imm = '0;
                if (XLEN == 64) dec_imm[5:0] = instr_in[25:20];
                else            dec_imm[4:0] = instr_in[24:20];
            end
            default: dec_imm[11:0] = instr_in[31:20];
        endcase
    end

`ifdef IMM_GEN_PC_TARGET_EN
    assign dec_word = {pc_in + dec_imm, imm_type_in, tag_in, dec_imm};
    assign {target_out, imm_type_out, tag_out, imm_out} = or_data;
`else
    assign dec_word = {imm_type_in, tag_in, dec_imm};
    assign {imm_type_out, tag_out, imm_out} = or_data;
`endif

    logic accept;
    logic or_free;
    logic sk_valid_nxt;

    assign accept  = valid_in & ready_q;
    assign or_free = ~or_valid | ready_in;

    // A full skid implies a full OR, so it empties exactly when the OR drains.
    always_comb begin
        if (flush_in)      sk_valid_nxt = 1'b0;
        else if (sk_valid) sk_valid_nxt = ~or_free;
        else               sk_valid_nxt = ~or_free & accept;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
            ready_q  <= 1'b1;
            or_data  <= '0;
            sk_data  <= '0;
        end else begin
            sk_valid <= sk_valid_nxt;
            ready_q  <= ~sk_valid_nxt;
            if (flush_in) begin
                or_valid <= 1'b0;
            end else if (or_free) begin
                or_valid <= sk_valid | accept;
                if (sk_valid)    or_data <= sk_data;
                else if (accept) or_data <= dec_word;
            end else if (accept) begin
                sk_data <= dec_word;
            end
        end
    end

    assign valid_out = or_valid;
    assign ready_out = ready_q;

endmodule

// File: tb/tb_rv_imm_gen_pipe.sv
// tb/tb_rv_imm_gen_pipe.sv - directed self-checking bench for rv_imm_gen_pipe (XLEN 32 and 64)
module tb_rv_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, valid_in, ready_in;
    logic [31:7] instr;
    logic [2:0]  itype;
    logic [4:0]  tag;

    logic        rdy32, vld32, rdy64, vld64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  typ32, typ64;
    logic [4:0]  tag32, tag64;
`ifdef IMM_GEN_PC_TARGET_EN
    logic [31:0] pc32, tgt32;
    logic [63:0] pc64, tgt64;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv_imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(valid_in),
        .ready_out(rdy32), .instr_in(instr), .imm_type_in(itype), .tag_in(tag),
        .valid_out(vld32), .ready_in(ready_in), .imm_out(imm32), .imm_type_out(typ32),
`ifdef IMM_GEN_PC_TARGET_EN
        .pc_in(pc32), .target_out(tgt32),
`endif
        .tag_out(tag32)
    );

    rv_imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(valid_in),
        .ready_out(rdy64), .instr_in(instr), .imm_type_in(itype), .tag_in(tag),
        .valid_out(vld64), .ready_in(ready_in), .imm_out(imm64), .imm_type_out(typ64),
`ifdef IMM_GEN_PC_TARGET_EN
        .pc_in(pc64), .target_out(tgt64),
`endif
        .tag_out(tag64)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [2:0] t, input logic [4:0] g);
        valid_in = 1'b1;
        instr    = w[31:7];
        itype    = t;
        tag      = g;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic idle;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        instr = '0; itype = '0; tag = '0;
`ifdef IMM_GEN_PC_TARGET_EN
        pc32 = 32'h1000; pc64 = 64'h1000;
`endif
        idle(); idle();
        chk("rst_valid", {63'd0, vld32}, 64'd0);
        chk("rst_ready", {63'd0, rdy32}, 64'd1);
        chk("rst_imm", {32'd0, imm32}, 64'd0);
        chk("rst_type_tag", {56'd0, typ32, tag32}, 64'd0);
        rst_n = 1'b1;
        idle();

        // Single-word decodes with ready_in held high
        send(32'hFFF00093, 3'b001, 5'd3);
        chk("i_valid", {63'd0, vld32}, 64'd1);
        chk("i_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
        chk("i_tag_type", {56'd0, typ32, tag32}, {56'd0, 3'b001, 5'd3});
        chk("i_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        send(32'hFE000EE3, 3'b011, 5'd4);
        chk("b_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
`ifdef IMM_GEN_PC_TARGET_EN
        chk("b_tgt32", {32'd0, tgt32}, 64'h0000_0000_0000_0FFC);
        chk("b_tgt64", tgt64, 64'h0000_0000_0000_0FFC);
`endif
        send(32'h12345037, 3'b100, 5'd5);
        chk("u_imm32", {32'd0, imm32}, 64'h0000_0000_1234_5000);
        send(32'h000F9073, 3'b110, 5'd6);
        chk("csr_imm32", {32'd0, imm32}, 64'h0000_0000_0000_001F);
        send(32'hFE112E23, 3'b010, 5'd7);
        chk("s_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
        send(32'hFFDFF0EF, 3'b101, 5'd8);
        chk("j_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
        send(32'h03F0D093, 3'b111, 5'd9);
        chk("shamt_imm32", {32'd0, imm32}, 64'd31);
        chk("shamt_imm64", imm64, 64'd63);
        idle();
        chk("drain_empty", {63'd0, vld32}, 64'd0);

        // Stall: A in OR, B in SK, C held upstream, then drain in order
        ready_in = 1'b0;
        send(32'h00100093, 3'b001, 5'd1);
        chk("stall_a_valid", {62'd0, vld32, rdy32}, 64'd3);
        send(32'h00200093, 3'b001, 5'd2);
        chk("stall_b_ready", {63'd0, rdy32}, 64'd0);
        chk("stall_a_hold", {59'd0, tag32}, 64'd1);
        valid_in = 1'b1; instr = 25'h6001; itype = 3'b001; tag = 5'd3;
        idle();
        chk("stall_c_blocked", {63'd0, rdy32}, 64'd0);
        chk("stall_a_stable", {32'd0, imm32}, 64'd1);
        ready_in = 1'b1;
        idle();
        chk("order_b", {26'd0, vld32, tag32, imm32}, {26'd0, 1'b1, 5'd2, 32'd2});
        chk("order_b_ready", {63'd0, rdy32}, 64'd1);
        idle();
        chk("order_c", {26'd0, vld32, tag32, imm32}, {26'd0, 1'b1, 5'd3, 32'd3});
        valid_in = 1'b0;
        idle();
        chk("order_end", {63'd0, vld32}, 64'd0);

        // Flush with both entries full and a word offered
        ready_in = 1'b0;
        send(32'h00100093, 3'b001, 5'd1);
        send(32'h00200093, 3'b001, 5'd2);
        flush = 1'b1; valid_in = 1'b1; instr = 25'h6001; tag = 5'd3;
        idle();
        flush = 1'b0; valid_in = 1'b0;
        chk("flush_state", {62'd0, vld32, rdy32}, 64'd1);
        ready_in = 1'b1;
        idle();
        chk("flush_nothing", {63'd0, vld32}, 64'd0);

        // Asynchronous reset mid-stall
        ready_in = 1'b0;
        send(32'h00100093, 3'b001, 5'd1);
        send(32'h00200093, 3'b001, 5'd2);
        chk("pre_rst_full", {62'd0, vld32, rdy32}, 64'd2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vr", {62'd0, vld32, rdy32}, 64'd1);
        chk("async_rst_data", {24'd0, typ32, tag32, imm32}, 64'd0);
        idle();
        rst_n = 1'b1; ready_in = 1'b1;
        idle();
        chk("post_rst_empty", {63'd0, vld32}, 64'd0);
        send(32'h00500093, 3'b001, 5'd9);
        chk("post_rst_accept", {26'd0, vld32, tag32, imm32}, {26'd0, 1'b1, 5'd9, 32'd5});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
